// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 16-bit 5-stage pipeline (RUN/STALL/WAIT/FAULT).
// Optional stall-cycle counter enabled by PIPELINE_HAZARD_CTRL_STALL_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] id_read1_addr,
    input  logic [2:0] id_read2_addr,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [2:0] ex_write_addr,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       mem_timeout,
    output logic [1:0] state_out
`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_next;
    logic             w_load_use;
    logic             w_mem_stall;
    logic             w_mem_done;

    assign w_load_use = ex_mem_read && (ex_write_addr != 3'd0) &&
                        ((ex_write_addr == id_read1_addr) ||
                         (id_uses_rs2 && (ex_write_addr == id_read2_addr)));
    assign w_mem_stall = mem_req && !mem_ready;
    assign w_mem_done  = mem_req && mem_ready;
    assign state_out   = r_state;

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_timeout = 1'b0;
        w_next      = r_state;
        w_wait_next = r_wait_cnt;
        unique case (r_state)
            RUN, STALL: begin
                if (w_mem_stall) begin
                    w_next      = WAIT;
                    w_wait_next = CNT_ONE;
                end else if (branch_taken) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    w_next      = RUN;
                end else if (w_load_use && r_state == RUN) begin
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    w_next      = STALL;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    w_next    = RUN;
                end
            end
            WAIT: begin
                // The completing cycle still freezes; advance resumes next cycle.
                if (w_mem_done) begin
                    w_next      = RUN;
                    w_wait_next = '0;
                end else if (r_wait_cnt == TO_LAST) begin
                    w_next = FAULT;
                end else if (r_wait_cnt != CNT_MAX) begin
                    w_wait_next = r_wait_cnt + CNT_ONE;
                end
            end
            FAULT: begin
                mem_timeout = 1'b1;
            end
        endcase
        if (!rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            mem_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
        end
    end

`ifdef PIPELINE_HAZARD_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && r_state != FAULT &&
                     r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
